// File: rtl/pezaris_seq_multiplier.sv
// Iterative Pezaris/Baugh-Wooley multiplier that evaluates one full-adder row per clock.
// Latency: WIDTH cycles from accept to out_valid. Backpressure: holds p in DONE until out_ready; in_ready only in IDLE.
module pezaris_seq_multiplier #(
    parameter  int WIDTH = 8,
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 signed_mode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   p,
    output logic                 busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(WIDTH - 1);

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]     a_q, a_d;
    logic [WIDTH-1:0]     b_q, b_d;
    logic                 sm_q, sm_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [2*WIDTH-1:0]   p_q, p_d;
    logic                 in_ready_q, in_ready_d;

    logic                 last_row;
    logic [WIDTH-1:0]     pp_vec;
    logic [2*WIDTH-1:0]   row_vec;
    logic [2*WIDTH-1:0]   corr;
    logic [2*WIDTH-1:0]   row_sum;

    // Adder row: a position is type-1 (negated) in signed mode when exactly one of
    // "top multiplicand bit" and "last row" holds; the sign-bit product stays plain.
    always_comb begin
        last_row = (cnt_q == LAST_ROW);
        pp_vec   = '0;
        for (int j = 0; j < WIDTH; j++) begin
            pp_vec[j] = (a_q[j] & b_q[cnt_q]) ^ (sm_q & ((j == WIDTH - 1) ^ last_row));
        end
        row_vec = {{WIDTH{1'b0}}, pp_vec} << cnt_q;
        corr    = '0;
        if (sm_q && (cnt_q == '0)) begin
            corr[WIDTH]       = 1'b1;
            corr[2*WIDTH-1]   = 1'b1;
        end
        row_sum = acc_q + row_vec + corr;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        sm_d    = sm_q;
        acc_d   = acc_q;
        p_d     = p_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    a_d     = a;
                    b_d     = b;
                    sm_d    = signed_mode;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                acc_d = row_sum;
                cnt_d = cnt_q + 1'b1;
                if (last_row) begin
                    p_d     = row_sum;
                    cnt_d   = '0;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        in_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            a_q        <= '0;
            b_q        <= '0;
            sm_q       <= 1'b0;
            acc_q      <= '0;
            p_q        <= '0;
            in_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            a_q        <= a_d;
            b_q        <= b_d;
            sm_q       <= sm_d;
            acc_q      <= acc_d;
            p_q        <= p_d;
            in_ready_q <= in_ready_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q == RUN);
    assign p         = p_q;

endmodule

// File: tb/tb_pezaris_seq_multiplier.sv
// Directed and sweep bench for pezaris_seq_multiplier at WIDTH 8, 4 and 2.
module tb_pezaris_seq_multiplier;

    logic        clk;
    logic        rst_n;
    logic [31:0] a_s [3];
    logic [31:0] b_s [3];
    logic        iv [3];
    logic        sm [3];
    logic        ordy [3];
    logic        irdy [3];
    logic        ov [3];
    logic        bsy [3];
    logic [63:0] p_s [3];
    logic [15:0] p8;
    logic [7:0]  p4;
    logic [3:0]  p2;

    int pass_cnt = 0;
    int tot_cnt  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    pezaris_seq_multiplier #(.WIDTH(8)) u_w8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(irdy[0]),
        .a(a_s[0][7:0]), .b(b_s[0][7:0]), .signed_mode(sm[0]),
        .out_valid(ov[0]), .out_ready(ordy[0]), .p(p8), .busy(bsy[0])
    );
    pezaris_seq_multiplier #(.WIDTH(4)) u_w4 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(irdy[1]),
        .a(a_s[1][3:0]), .b(b_s[1][3:0]), .signed_mode(sm[1]),
        .out_valid(ov[1]), .out_ready(ordy[1]), .p(p4), .busy(bsy[1])
    );
    pezaris_seq_multiplier #(.WIDTH(2)) u_w2 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(irdy[2]),
        .a(a_s[2][1:0]), .b(b_s[2][1:0]), .signed_mode(sm[2]),
        .out_valid(ov[2]), .out_ready(ordy[2]), .p(p2), .busy(bsy[2])
    );

    assign p_s[0] = {48'd0, p8};
    assign p_s[1] = {56'd0, p4};
    assign p_s[2] = {60'd0, p2};

    function automatic logic [63:0] model(input int w, input logic [31:0] aa, input logic [31:0] bb,
                                          input logic smm);
        longint x;
        longint y;
        logic [63:0] mask;
        mask = (64'd1 << (2 * w)) - 64'd1;
        x = longint'(aa);
        y = longint'(bb);
        if (smm && aa[w-1]) x = x - (longint'(1) << w);
        if (smm && bb[w-1]) y = y - (longint'(1) << w);
        return 64'(x * y) & mask;
    endfunction

    // One full transaction on instance k: wait for in_ready, accept, count edges to out_valid, drain.
    task automatic run_op(input int k, input logic [31:0] aa, input logic [31:0] bb, input logic smm,
                          output logic [63:0] pp, output int lat);
        int t;
        t = 0;
        while (irdy[k] !== 1'b1 && t < 64) begin
            @(posedge clk); #1; t++;
        end
        a_s[k] = aa; b_s[k] = bb; sm[k] = smm; iv[k] = 1'b1;
        @(posedge clk); #1;
        iv[k] = 1'b0;
        lat = 0;
        while (ov[k] !== 1'b1 && lat < 64) begin
            @(posedge clk); #1; lat++;
        end
        pp = p_s[k];
        ordy[k] = 1'b1;
        @(posedge clk); #1;
        ordy[k] = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        tot_cnt++;
        if (irdy[0] !== 1'b0 || ov[0] !== 1'b0 || bsy[0] !== 1'b0 || p8 !== 16'h0) begin
            $display("FAIL reset_state: in_ready=%b out_valid=%b busy=%b p=%h, want 0 0 0 0000",
                     irdy[0], ov[0], bsy[0], p8);
        end else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        tot_cnt++;
        if (irdy[0] !== 1'b0) $display("FAIL ready_before_edge: in_ready=%b want 0", irdy[0]);
        else pass_cnt++;
        @(posedge clk); #1;
        tot_cnt++;
        if (irdy[0] !== 1'b1 || irdy[1] !== 1'b1 || irdy[2] !== 1'b1)
            $display("FAIL ready_after_edge: in_ready=%b%b%b want 111", irdy[0], irdy[1], irdy[2]);
        else pass_cnt++;
    endtask

    task automatic test_unsigned_latency();
        int bad_busy;
        bad_busy = 0;
        a_s[0] = 32'hFF; b_s[0] = 32'hFF; sm[0] = 1'b0; iv[0] = 1'b1;
        @(posedge clk); #1;
        iv[0] = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (bsy[0] !== 1'b1 || ov[0] !== 1'b0) bad_busy++;
            @(posedge clk); #1;
        end
        tot_cnt++;
        if (bad_busy != 0) $display("FAIL busy_window: %0d bad cycles, want 0", bad_busy);
        else pass_cnt++;
        tot_cnt++;
        if (ov[0] !== 1'b1 || bsy[0] !== 1'b0 || p8 !== 16'hFE01)
            $display("FAIL unsigned_ff_ff: out_valid=%b busy=%b p=%h, want 1 0 fe01", ov[0], bsy[0], p8);
        else pass_cnt++;
        ordy[0] = 1'b1;
        @(posedge clk); #1;
        ordy[0] = 1'b0;
        tot_cnt++;
        if (ov[0] !== 1'b0 || irdy[0] !== 1'b1)
            $display("FAIL drain: out_valid=%b in_ready=%b, want 0 1", ov[0], irdy[0]);
        else pass_cnt++;
    endtask

    task automatic test_signed();
        logic [63:0] pp;
        int lat;
        run_op(0, 32'h80, 32'h80, 1'b1, pp, lat);
        tot_cnt++;
        if (pp !== 64'h4000 || lat != 8) $display("FAIL signed_80_80: p=%h lat=%0d, want 4000 8", pp, lat);
        else pass_cnt++;
        run_op(0, 32'h80, 32'h7F, 1'b1, pp, lat);
        tot_cnt++;
        if (pp !== 64'hC080) $display("FAIL signed_80_7f: p=%h, want c080", pp);
        else pass_cnt++;
        run_op(0, 32'hFF, 32'hFF, 1'b1, pp, lat);
        tot_cnt++;
        if (pp !== 64'h0001) $display("FAIL signed_ff_ff: p=%h, want 0001", pp);
        else pass_cnt++;
        run_op(0, 32'hFF, 32'hFF, 1'b0, pp, lat);
        tot_cnt++;
        if (pp !== 64'hFE01) $display("FAIL unsigned_ff_ff_again: p=%h, want fe01", pp);
        else pass_cnt++;
    endtask

    task automatic test_backpressure();
        logic [63:0] pp;
        int lat;
        int bad;
        a_s[0] = 32'h0F; b_s[0] = 32'h11; sm[0] = 1'b0; iv[0] = 1'b1;
        @(posedge clk); #1;
        // Keep offering a different operand pair throughout RUN and DONE.
        a_s[0] = 32'h3; b_s[0] = 32'h4;
        lat = 0;
        while (ov[0] !== 1'b1 && lat < 64) begin
            @(posedge clk); #1; lat++;
        end
        tot_cnt++;
        if (lat != 8) $display("FAIL bp_latency: lat=%0d want 8", lat);
        else pass_cnt++;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            if (ov[0] !== 1'b1 || p8 !== 16'h00FF || irdy[0] !== 1'b0) bad++;
            @(posedge clk); #1;
        end
        tot_cnt++;
        if (bad != 0) $display("FAIL bp_stall: %0d unstable cycles, p=%h want 00ff", bad, p8);
        else pass_cnt++;
        iv[0] = 1'b0;
        ordy[0] = 1'b1;
        @(posedge clk); #1;
        ordy[0] = 1'b0;
        tot_cnt++;
        if (ov[0] !== 1'b0 || p8 !== 16'h00FF || irdy[0] !== 1'b1)
            $display("FAIL bp_release: out_valid=%b p=%h in_ready=%b, want 0 00ff 1", ov[0], p8, irdy[0]);
        else pass_cnt++;
        run_op(0, 32'h3, 32'h4, 1'b0, pp, lat);
        tot_cnt++;
        if (pp !== 64'h000C || lat != 8) $display("FAIL bp_next: p=%h lat=%0d, want 000c 8", pp, lat);
        else pass_cnt++;
    endtask

    task automatic test_mid_reset();
        logic [63:0] pp;
        int lat;
        a_s[0] = 32'h12; b_s[0] = 32'h34; sm[0] = 1'b0; iv[0] = 1'b1;
        @(posedge clk); #1;
        iv[0] = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        tot_cnt++;
        if (ov[0] !== 1'b0 || bsy[0] !== 1'b0 || p8 !== 16'h0 || irdy[0] !== 1'b0)
            $display("FAIL mid_reset: out_valid=%b busy=%b p=%h in_ready=%b, want 0 0 0000 0",
                     ov[0], bsy[0], p8, irdy[0]);
        else pass_cnt++;
        @(posedge clk); #3;
        rst_n = 1'b1;
        @(posedge clk); #1;
        tot_cnt++;
        if (ov[0] !== 1'b0 || irdy[0] !== 1'b1)
            $display("FAIL post_reset: out_valid=%b in_ready=%b, want 0 1", ov[0], irdy[0]);
        else pass_cnt++;
        run_op(0, 32'h7, 32'h6, 1'b0, pp, lat);
        tot_cnt++;
        if (pp !== 64'h002A || lat != 8) $display("FAIL post_reset_op: p=%h lat=%0d, want 002a 8", pp, lat);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        logic [63:0] pp;
        int lat;
        int bad;
        bad = 0;
        ordy[0] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            if (ov[0] !== 1'b0 || irdy[0] !== 1'b1) bad++;
        end
        ordy[0] = 1'b0;
        tot_cnt++;
        if (bad != 0) $display("FAIL idle_out_ready: %0d disturbed cycles, want 0", bad);
        else pass_cnt++;
        run_op(0, 32'hC8, 32'h0A, 1'b0, pp, lat);
        tot_cnt++;
        if (pp !== 64'h07D0) $display("FAIL b2b_first: p=%h, want 07d0", pp);
        else pass_cnt++;
        run_op(0, 32'hFE, 32'h05, 1'b1, pp, lat);
        tot_cnt++;
        if (pp !== 64'hFFF6) $display("FAIL b2b_second: p=%h, want fff6", pp);
        else pass_cnt++;
    endtask

    task automatic test_exhaustive_w4();
        logic [63:0] pp;
        logic [63:0] exp_p;
        int lat;
        for (int m = 0; m < 2; m++) begin
            for (int x = 0; x < 16; x++) begin
                for (int y = 0; y < 16; y++) begin
                    run_op(1, 32'(x), 32'(y), m[0], pp, lat);
                    exp_p = model(4, 32'(x), 32'(y), m[0]);
                    tot_cnt++;
                    if (pp !== exp_p || lat != 4)
                        $display("FAIL w4 m=%0d a=%0d b=%0d: p=%h lat=%0d, want %h 4", m, x, y, pp, lat, exp_p);
                    else pass_cnt++;
                end
            end
        end
    endtask

    task automatic test_random(input int k, input int w);
        logic [63:0] pp;
        logic [63:0] exp_p;
        logic [31:0] ra;
        logic [31:0] rb;
        logic [31:0] msk;
        int lat;
        msk = (32'd1 << w) - 32'd1;
        for (int i = 0; i < 1000; i++) begin
            ra = $urandom() & msk;
            rb = $urandom() & msk;
            run_op(k, ra, rb, i[0], pp, lat);
            exp_p = model(w, ra, rb, i[0]);
            tot_cnt++;
            if (pp !== exp_p || lat != w)
                $display("FAIL rand w%0d sm=%0d a=%h b=%h: p=%h lat=%0d, want %h %0d",
                         w, i[0], ra, rb, pp, lat, exp_p, w);
            else pass_cnt++;
        end
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            a_s[k] = '0; b_s[k] = '0; iv[k] = 1'b0; sm[k] = 1'b0; ordy[k] = 1'b0;
        end
        test_reset();
        test_unsigned_latency();
        test_signed();
        test_backpressure();
        test_mid_reset();
        test_back_to_back();
        test_exhaustive_w4();
        test_random(0, 8);
        test_random(2, 2);
        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule
